// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin multi-host bus (rr_bus).
package bus_pkg;

    // Bus controller states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DERR = 2'd2;

    // Error causes reported on host_err_o
    localparam logic [1:0] ERR_DECODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Default watchdog limit (only meaningful with BUS_TIMEOUT_EN)
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr_i, scanning cyclically upward. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Scan N positions starting at the pointer and take the first request
    always_comb begin
        int unsigned c;
        c       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            c = (32'(ptr_i) + k) % N;
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                idx_o    = IW'(c);
                gnt_o[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_bus.sv
// Round-robin multi-host / multi-device bus with base/mask address decode and
// one transaction in flight. Define BUS_TIMEOUT_EN to enable the watchdog
// that terminates hung device transactions after TimeoutCycles WAIT cycles.
module rr_bus
    import bus_pkg::*;
#(
    parameter int unsigned NrHosts       = 2,
    parameter int unsigned NrDevices     = 3,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,

    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,

    output logic [NrDevices-1:0]              device_req_o,
    output logic [NrDevices*AddressWidth-1:0] device_addr_o,
    output logic [NrDevices-1:0]              device_we_o,
    output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
    output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
    input  logic [NrDevices-1:0]              device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
    input  logic [NrDevices-1:0]              device_err_i,

    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
);

    localparam int unsigned HW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DW = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int unsigned BW = DataWidth / 8;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] owner_q, owner_d;
    logic [DW-1:0] target_q, target_d;

    logic [NrHosts-1:0]      arb_gnt;
    logic [HW-1:0]           arb_idx;
    logic                    arb_valid;
    logic [AddressWidth-1:0] gnt_addr;
    logic                    dec_hit;
    logic [DW-1:0]           dec_idx;

    rr_arbiter #(
        .N (NrHosts)
    ) u_arb (
        .req_i   (host_req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign gnt_addr = host_addr_i[32'(arb_idx)*AddressWidth +: AddressWidth];

    // Address decode of the candidate host; lowest matching device wins
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!dec_hit &&
                ((gnt_addr & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth])
                 == cfg_device_addr_base_i[d*AddressWidth +: AddressWidth])) begin
                dec_hit = 1'b1;
                dec_idx = DW'(d);
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tmo;

    assign tmo = (cnt_q == TW'(TimeoutCycles));

    // Watchdog counts WAIT cycles; held at zero elsewhere so it starts clean
    always_comb begin
        cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    end

    // Watchdog register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif

    // Transaction FSM and combinational host/device routing
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        target_d       = target_q;
        host_gnt_o     = '0;
        host_rvalid_o  = '0;
        host_rdata_o   = '0;
        host_err_o     = '0;
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = '0;
        device_be_o    = '0;
        device_wdata_o = '0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    host_gnt_o = arb_gnt;
                    owner_d    = arb_idx;
                    ptr_d      = (32'(arb_idx) == NrHosts - 1) ? '0 : arb_idx + 1'b1;
                    if (dec_hit) begin
                        device_req_o[dec_idx] = 1'b1;
                        device_addr_o[32'(dec_idx)*AddressWidth +: AddressWidth] = gnt_addr;
                        device_we_o[dec_idx] = host_we_i[arb_idx];
                        device_be_o[32'(dec_idx)*BW +: BW] =
                            host_be_i[32'(arb_idx)*BW +: BW];
                        device_wdata_o[32'(dec_idx)*DataWidth +: DataWidth] =
                            host_wdata_i[32'(arb_idx)*DataWidth +: DataWidth];
                        target_d = dec_idx;
                        state_d  = WAIT;
                    end else begin
                        state_d = DERR;
                    end
                end
            end
            WAIT: begin
                if (device_rvalid_i[target_q]) begin
                    host_rvalid_o[owner_q] = 1'b1;
                    host_err_o[owner_q]    = device_err_i[target_q];
                    host_rdata_o[32'(owner_q)*DataWidth +: DataWidth] =
                        device_rdata_i[32'(target_q)*DataWidth +: DataWidth];
                    state_d = IDLE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (tmo) begin
                    host_rvalid_o[owner_q] = 1'b1;
                    host_err_o[owner_q]    = 1'b1;
                    state_d                = IDLE;
                end
`endif
            end
            DERR: begin
                host_rvalid_o[owner_q] = 1'b1;
                host_err_o[owner_q]    = 1'b1;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Nothing leaves the bus while reset is applied
        if (!rst_ni) begin
            host_gnt_o     = '0;
            host_rvalid_o  = '0;
            host_rdata_o   = '0;
            host_err_o     = '0;
            device_req_o   = '0;
            device_addr_o  = '0;
            device_we_o    = '0;
            device_be_o    = '0;
            device_wdata_o = '0;
        end
    end

    // State, pointer, owner and target registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_rr_bus.sv
// Directed self-checking bench for rr_bus (2 hosts, 3 devices, 32-bit).
// Define BUS_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_rr_bus;
    import bus_pkg::*;

    localparam int unsigned NH = 2;
    localparam int unsigned ND = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = DEFAULT_TIMEOUT_CYCLES;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NH-1:0]     host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [NH*AW-1:0]  host_addr;
    logic [NH*DW/8-1:0] host_be;
    logic [NH*DW-1:0]  host_wdata, host_rdata;
    logic [ND-1:0]     dev_req, dev_we, dev_rvalid, dev_err;
    logic [ND*AW-1:0]  dev_addr, cfg_base, cfg_mask;
    logic [ND*DW/8-1:0] dev_be;
    logic [ND*DW-1:0]  dev_wdata, dev_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_bus #(
        .NrHosts       (NH),
        .NrDevices     (ND),
        .DataWidth     (DW),
        .AddressWidth  (AW),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .host_req_i             (host_req),
        .host_gnt_o             (host_gnt),
        .host_addr_i            (host_addr),
        .host_we_i              (host_we),
        .host_be_i              (host_be),
        .host_wdata_i           (host_wdata),
        .host_rvalid_o          (host_rvalid),
        .host_rdata_o           (host_rdata),
        .host_err_o             (host_err),
        .device_req_o           (dev_req),
        .device_addr_o          (dev_addr),
        .device_we_o            (dev_we),
        .device_be_o            (dev_be),
        .device_wdata_o         (dev_wdata),
        .device_rvalid_i        (dev_rvalid),
        .device_rdata_i         (dev_rdata),
        .device_err_i           (dev_err),
        .cfg_device_addr_base_i (cfg_base),
        .cfg_device_addr_mask_i (cfg_mask)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the middle of the next cycle; inputs are driven here
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        host_req   = '0;
        dev_rvalid = '0;
        dev_err    = '0;
        dev_rdata  = '0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_gnt"},    128'(host_gnt),    '0);
        check_eq({tag, "_rvalid"}, 128'(host_rvalid), '0);
        check_eq({tag, "_err"},    128'(host_err),    '0);
        check_eq({tag, "_rdata"},  128'(host_rdata),  '0);
        check_eq({tag, "_dreq"},   128'(dev_req),     '0);
        check_eq({tag, "_daddr"},  128'(dev_addr),    '0);
        check_eq({tag, "_dwdata"}, 128'(dev_wdata),   '0);
    endtask

    initial begin
        logic [NH-1:0] exp_oh;
        rst_n      = 1'b0;
        host_addr  = '0;
        host_we    = '0;
        host_be    = '0;
        host_wdata = '0;
        idle_inputs();
        cfg_base = {32'h0030_0000, 32'h0020_0000, 32'h0010_0000};
        cfg_mask = {32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000};

        // Reset state
        tick(); tick();
        #1 check_quiet("rst_hold");
        tick(); rst_n = 1'b1;
        #1 check_quiet("rst_idle");

        // Single read from host0 to device0
        tick();
        host_req  = 2'b01;
        host_addr = {32'h0, 32'h0010_0004};
        host_be   = 8'h0F;
        #1;
        check_eq("rd_gnt",   128'(host_gnt), 128'h1);
        check_eq("rd_dreq",  128'(dev_req),  128'h1);
        check_eq("rd_daddr", 128'(dev_addr), 128'h0010_0004);
        check_eq("rd_dbe",   128'(dev_be),   128'h00F);
        tick();
        host_req   = '0;
        dev_rvalid = 3'b001;
        dev_rdata  = {32'h0, 32'h0, 32'hDEAD_BEEF};
        #1;
        check_eq("rd_rvalid", 128'(host_rvalid), 128'h1);
        check_eq("rd_rdata",  128'(host_rdata),  128'hDEAD_BEEF);
        check_eq("rd_err",    128'(host_err),    128'h0);
        check_eq("rd_nognt",  128'(host_gnt),    128'h0);
        tick(); idle_inputs();
        #1 check_eq("rd_done", 128'(host_rvalid), 128'h0);

        // Unmapped write from host1
        tick();
        host_req   = 2'b10;
        host_addr  = {32'h0050_0000, 32'h0};
        host_we    = 2'b10;
        host_wdata = {32'hCAFE_F00D, 32'h0};
        #1;
        check_eq("um_gnt",  128'(host_gnt), 128'h2);
        check_eq("um_dreq", 128'(dev_req),  128'h0);
        tick(); host_req = '0; host_we = '0;
        #1;
        check_eq("um_rvalid", 128'(host_rvalid), 128'h2);
        check_eq("um_err",    128'(host_err),    128'h2);
        check_eq("um_rdata",  128'(host_rdata),  128'h0);
        tick();

        // Fairness: both hosts request continuously
        host_addr = {32'h0020_0000, 32'h0010_0000};
        for (int t = 0; t < 8; t++) begin
            exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            host_req   = 2'b11;
            dev_rvalid = '0;
            #1;
            check_eq($sformatf("rr_gnt%0d", t), 128'(host_gnt), 128'(exp_oh));
            check_eq($sformatf("rr_dreq%0d", t), 128'(dev_req),
                     (t % 2 == 0) ? 128'h1 : 128'h2);
            tick();
            dev_rvalid = (t % 2 == 0) ? 3'b001 : 3'b010;
            dev_rdata  = 96'(t + 16) << ((t % 2) * 32);
            #1;
            check_eq($sformatf("rr_rvalid%0d", t), 128'(host_rvalid), 128'(exp_oh));
            check_eq($sformatf("rr_rdata%0d", t), 128'(host_rdata),
                     128'(64'(t + 16) << ((t % 2) * 32)));
            check_eq($sformatf("rr_hold%0d", t), 128'(host_gnt), 128'h0);
            tick();
        end
        idle_inputs();

        // Device error from the timer; a non-target rvalid is ignored
        tick();
        host_req  = 2'b01;
        host_addr = {32'h0, 32'h0030_0010};
        #1;
        check_eq("te_gnt",  128'(host_gnt), 128'h1);
        check_eq("te_dreq", 128'(dev_req),  128'h4);
        check_eq("te_daddr", 128'(dev_addr), 128'h0030_0010 << 64);
        tick(); host_req = '0; dev_rvalid = 3'b001;
        #1 check_eq("te_nontarget", 128'(host_rvalid), 128'h0);
        tick();
        dev_rvalid = 3'b100;
        dev_err    = 3'b100;
        dev_rdata  = {32'h1234_5678, 32'h0, 32'h0};
        #1;
        check_eq("te_rvalid", 128'(host_rvalid), 128'h1);
        check_eq("te_err",    128'(host_err),    128'h1);
        check_eq("te_rdata",  128'(host_rdata),  128'h1234_5678);
        tick(); idle_inputs();

`ifdef BUS_TIMEOUT_EN
        // Watchdog: device2 never answers
        tick();
        host_req  = 2'b01;
        host_addr = {32'h0, 32'h0030_0020};
        #1 check_eq("to_gnt", 128'(host_gnt), 128'h1);
        for (int w = 0; w < 4; w++) begin
            tick(); host_req = '0;
            #1 check_eq($sformatf("to_wait%0d", w), 128'(host_rvalid), 128'h0);
        end
        tick();
        #1;
        check_eq("to_rvalid", 128'(host_rvalid), 128'h1);
        check_eq("to_err",    128'(host_err),    128'h1);
        check_eq("to_rdata",  128'(host_rdata),  128'h0);
        tick();
        tick(); dev_rvalid = 3'b100;
        #1 check_eq("to_late", 128'(host_rvalid), 128'h0);
        tick(); idle_inputs();
`endif

        // Reset while in WAIT
        tick();
        host_req  = 2'b10;
        host_addr = {32'h0020_0008, 32'h0};
        #1;
        check_eq("rw_gnt",  128'(host_gnt), 128'h2);
        check_eq("rw_dreq", 128'(dev_req),  128'h2);
        tick(); host_req = '0; rst_n = 1'b0;
        tick(); rst_n = 1'b1; dev_rvalid = 3'b010; dev_rdata = {32'h0, 32'h5555_AAAA, 32'h0};
        #1 check_quiet("rw_after");
        tick();
        dev_rvalid = '0;
        dev_rdata  = '0;
        host_req   = 2'b11;
        host_addr  = {32'h0020_0000, 32'h0010_0000};
        #1 check_eq("rw_first_gnt", 128'(host_gnt), 128'h1);
        tick(); host_req = 2'b10; dev_rvalid = 3'b001;
        #1 check_eq("rw_first_rv", 128'(host_rvalid), 128'h1);
        tick(); idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_bus.md
Name: rr_bus

Overview:
- Parametrised successor to the single-host SoC bus.
- Connects NrHosts requesters (core data port, debug module, future DMA) to NrDevices slaves (ram, console, timer, ...).
- Arbitration is round-robin with one transaction in flight, and addresses are decoded through base/mask pairs.
- Unmapped accesses and device errors are returned to the owning host. An optional watchdog terminates hung transactions.

Parameters:
- NrHosts, 2, number of host ports (1..8)
- NrDevices, 3, number of device ports (1..16)
- DataWidth, 32, data bus width
- AddressWidth, 32, address bus width
- TimeoutCycles, 255, watchdog limit in cycles; used only with BUS_TIMEOUT_EN

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- host_req_i  in  NrHosts  request per host
- host_gnt_o  out  NrHosts  one-hot grant pulse
- host_addr_i  in  NrHosts*AddressWidth  flattened addresses, host h at slice h
- host_we_i  in  NrHosts  write enable
- host_be_i  in  NrHosts*DataWidth/8  byte enables
- host_wdata_i  in  NrHosts*DataWidth  write data
- host_rvalid_o  out  NrHosts  response valid, one-hot
- host_rdata_o  out  NrHosts*DataWidth  read data; only the owner's slice is meaningful
- host_err_o  out  NrHosts  error flag, qualified by rvalid
- device_req_o  out  NrDevices  request per device
- device_addr_o / device_we_o / device_be_o / device_wdata_o  out  flattened per device  forwarded from the granted host
- device_rvalid_i  in  NrDevices  response valid
- device_rdata_i  in  NrDevices*DataWidth  read data
- device_err_i  in  NrDevices  device error
- cfg_device_addr_base_i  in  NrDevices*AddressWidth  base address per device
- cfg_device_addr_mask_i  in  NrDevices*AddressWidth  mask per device

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - state=IDLE, rr pointer=0, owner/target registers=0.
  - All outputs are 0: gnt, rvalid, err, rdata, device_req, and the forwarded fields.
  - An in-flight transaction is dropped. A device rvalid arriving after reset is ignored.
- Host protocol:
  - The host holds req, addr, we, be and wdata stable until it sees gnt.
  - gnt is a single-cycle pulse, combinational in the cycle it is granted.
  - Exactly one rvalid follows each gnt, at least 1 cycle later. This applies to writes too.
- IDLE:
  - If any req is set, grant the first requesting host at or after the pointer, scanning cyclically upward.
  - Register the owner; set pointer = owner+1 mod NrHosts.
  - Decode the address: device d matches when (addr & mask[d]) == base[d]. If several match, the lowest index wins.
  - Hit: assert device_req[d] for one cycle in the same cycle as gnt, with the fields forwarded; go to WAIT.
  - Miss: no device_req; go to DERR.
- WAIT:
  - No grants are issued.
  - When device_rvalid[target] is seen, pass rdata/err to the owner combinationally with host_rvalid[owner]=1 in the same cycle, then return to IDLE.
  - rvalid from a non-target device is ignored.
- DERR: host_rvalid[owner]=1, err=1, rdata=0 for one cycle, then IDLE.
- Throughput: the next grant is issued no earlier than the cycle after the response (at best 2 cycles per transaction).
- Simultaneous requests: exactly one gnt per cycle. Losing hosts keep req asserted.
- Fairness: with N hosts requesting continuously, each host is granted once in every N grants.
- Device outputs on non-target slices are held at 0.
- NrHosts=1 degenerates to a fixed grant; the pointer stays at 0.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A counter (width clog2(TimeoutCycles+1)) clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TimeoutCycles with no target rvalid: host_rvalid[owner]=1, err=1, rdata=0, go to IDLE.
  - A late device rvalid is then ignored.
  - If the counter reaches the limit in the same cycle that rvalid arrives, the device response wins.
- BUS_TIMEOUT_EN undefined: no counter; WAIT persists until the device responds.

Decomposition:
- bus_pkg:
  - state encoding: IDLE=2'd0, WAIT=2'd1, DERR=2'd2
  - ERR_DECODE / ERR_TIMEOUT constants
  - default TimeoutCycles
- Sub-module rr_arbiter:
  - parameter N
  - inputs: req vector, pointer
  - outputs: one-hot grant, encoded index, any_valid
  - purely combinational; the pointer register lives in rr_bus.

Test Plan:
- Single read, host0 addr 0x100004, device0 returns 0xDEADBEEF one cycle later -> gnt0 at cycle 0, device_req0 at cycle 0, host_rvalid0=1 with rdata 0xDEADBEEF and err=0 at cycle 1.
- Host0 and host1 request continuously, 8 transactions -> grant order 0,1,0,1,0,1,0,1; each grant is followed by exactly one rvalid to the same host.
- Host1 writes addr 0x500000 (unmapped) -> gnt1, no device_req, next cycle host_rvalid1=1, err=1, rdata=0.
- Timer asserts device_err on a response to host0 addr 0x300010 -> host_err0=1 in the same cycle as host_rvalid0.
- BUS_TIMEOUT_EN, TimeoutCycles=4, device2 never responds -> host_rvalid=1, err=1 after 4 WAIT cycles; a device rvalid injected 2 cycles later produces no host rvalid.
- rst_ni=0 asserted for one cycle while in WAIT -> all outputs 0 the next cycle; the following device rvalid is ignored; the first grant after reset goes to host0.
